// File: rtl/VX_perf_pkg.sv
// Shared definitions for the memory-system perf sampler: counter count, index order, FSM states.
// No logic of its own; the saturating-increment helper is combinational.
// No flow control here.
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

package VX_perf_pkg;

    localparam int PERF_MEMSYS_NUM_CTRS = 15;

    typedef enum logic [3:0] {
        PERF_ICACHE_READS        = 4'd0,
        PERF_ICACHE_READ_MISSES  = 4'd1,
        PERF_DCACHE_READS        = 4'd2,
        PERF_DCACHE_WRITES       = 4'd3,
        PERF_DCACHE_READ_MISSES  = 4'd4,
        PERF_DCACHE_WRITE_MISSES = 4'd5,
        PERF_DCACHE_BANK_STALLS  = 4'd6,
        PERF_DCACHE_MSHR_STALLS  = 4'd7,
        PERF_SMEM_READS          = 4'd8,
        PERF_SMEM_WRITES         = 4'd9,
        PERF_SMEM_BANK_STALLS    = 4'd10,
        PERF_MEM_READS           = 4'd11,
        PERF_MEM_WRITES          = 4'd12,
        PERF_MEM_LATENCY         = 4'd13,
        PERF_DUP                 = 4'd14
    } perf_memsys_idx_e;

    typedef enum logic {
        SAMPLER_IDLE   = 1'b0,
        SAMPLER_STREAM = 1'b1
    } sampler_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/VX_perf_interval_timer.sv
// Periodic trigger source: down-counter reloaded from interval_cfg, pulses expire when it reads 1.
// expire is combinational from the current count; reload happens at the same edge.
// No backpressure: expiries are fire-and-forget, the consumer decides whether to drop them.
module VX_perf_interval_timer #(
    parameter int INTERVAL_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  interval_en,
    input  logic [INTERVAL_W-1:0] interval_cfg,
    output logic                  expire
);

    logic [INTERVAL_W-1:0] cnt;
    logic                  run;

    assign run    = interval_en && (interval_cfg != '0);
    assign expire = run && (cnt == INTERVAL_W'(1));

    // A zero count only occurs after reset; the first enabled cycle loads the period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= interval_cfg;
        end else if (cnt <= INTERVAL_W'(1)) begin
            cnt <= interval_cfg;
        end else begin
            cnt <= cnt - INTERVAL_W'(1);
        end
    end

endmodule

// File: rtl/vx_perf_memsys_sampler.sv
// Snapshots 15 memsys perf counters on trig_req/timer and streams them out by index (PERF_MEMSYS_DELTA_EN: per-interval deltas).
// Capture at the trigger edge; first word valid the next cycle, one word per handshake.
// out_data/out_idx hold while out_valid && !out_ready; triggers while busy are dropped and counted.
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

module vx_perf_memsys_sampler
    import VX_perf_pkg::*;
#(
    parameter int CTR_W      = `PERF_CTR_BITS,
    parameter int NUM_CTRS   = PERF_MEMSYS_NUM_CTRS,
    parameter int INTERVAL_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CTRS*CTR_W-1:0] ctr_in,
    input  logic                      trig_req,
    input  logic                      interval_en,
    input  logic [INTERVAL_W-1:0]     interval_cfg,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [3:0]                out_idx,
    output logic [CTR_W-1:0]          out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic [7:0]                drop_cnt
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_CTRS - 1);

    sampler_state_e   state, state_nxt;
    logic [3:0]       idx;
    logic [CTR_W-1:0] shadow [NUM_CTRS];
    logic             timer_expire;
    logic             trigger;
    logic             capture;
    logic             advance;
    logic             dropped;

    VX_perf_interval_timer #(
        .INTERVAL_W (INTERVAL_W)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .interval_en  (interval_en),
        .interval_cfg (interval_cfg),
        .expire       (timer_expire)
    );

    assign trigger = trig_req | timer_expire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SAMPLER_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        advance   = 1'b0;
        dropped   = 1'b0;
        out_valid = 1'b0;
        case (state)
            SAMPLER_IDLE: begin
                if (trigger) begin
                    capture   = 1'b1;
                    state_nxt = SAMPLER_STREAM;
                end
            end
            SAMPLER_STREAM: begin
                out_valid = 1'b1;
                // Still STREAM on the final handshake, so a trigger there is lost too.
                dropped   = trigger;
                if (out_ready) begin
                    advance = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_nxt = SAMPLER_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (capture) begin
            idx <= '0;
        end else if (advance) begin
            idx <= (idx == LAST_IDX) ? 4'd0 : idx + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (dropped) begin
            drop_cnt <= sat_inc8(drop_cnt);
        end
    end

`ifdef PERF_MEMSYS_DELTA_EN
    logic [CTR_W-1:0] prev [NUM_CTRS];

    // Modular subtract: a counter that wrapped since the last capture still yields the true delta.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CTRS; i++) begin
                shadow[i] <= '0;
                prev[i]   <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_CTRS; i++) begin
                shadow[i] <= ctr_in[i*CTR_W +: CTR_W] - prev[i];
                prev[i]   <= ctr_in[i*CTR_W +: CTR_W];
            end
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CTRS; i++) begin
                shadow[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_CTRS; i++) begin
                shadow[i] <= ctr_in[i*CTR_W +: CTR_W];
            end
        end
    end
`endif

    assign busy     = (state == SAMPLER_STREAM);
    assign out_idx  = idx;
    assign out_data = out_valid ? shadow[idx] : '0;
    assign out_last = out_valid && (idx == LAST_IDX);

endmodule
